// File: rtl/escaneo_display_ctrl.sv
// escaneo_display_ctrl: 4-digit 7-segment scan controller with blanking and frame-aligned pattern updates
module escaneo_display_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] estado_in,
  input  logic       estado_valid,
  output logic       estado_ready,
  output logic [1:0] conteo,
  output logic [7:0] estado,
  output logic       blank,
  output logic       frame_done
);
  typedef enum logic [1:0] {SHOW, BLANK, OFF} state_t;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       conteo_n;
  logic [7:0]       pend, pend_n, estado_n;
  logic             full, full_n, fd_n, show_end, slot_end, accept, apply;
  always_comb begin
    show_end = state == SHOW && cnt == SHOW_LAST;
    slot_end = state == BLANK && cnt == BLANK_LAST;
    accept   = estado_valid && !full;
    // pending is released at a frame boundary, on entry to OFF, or any time while OFF
    apply    = full && (state == OFF || !enable || (slot_end && conteo == 2'd3));
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    conteo_n = conteo;
    fd_n     = 1'b0;
    if (!enable || state == OFF) begin
      state_n  = enable ? SHOW : OFF;
      cnt_n    = '0;
      conteo_n = '0;
    end else if (show_end) begin
      state_n = BLANK;
      cnt_n   = '0;
    end else if (slot_end) begin
      state_n  = SHOW;
      cnt_n    = '0;
      conteo_n = conteo + 2'd1;
      fd_n     = conteo == 2'd3;
    end
    full_n   = apply ? 1'b0 : (accept | full);
    pend_n   = accept ? estado_in : pend;
    estado_n = apply ? pend : estado;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW;
      cnt        <= '0;
      conteo     <= '0;
      estado     <= '0;
      pend       <= '0;
      full       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      conteo     <= conteo_n;
      estado     <= estado_n;
      pend       <= pend_n;
      full       <= full_n;
      frame_done <= fd_n;
    end
  end
  assign estado_ready = !full;
  assign blank        = state != SHOW;
endmodule

// File: tb/tb_escaneo_display_ctrl.sv
// tb_escaneo_display_ctrl: frame-time reference model plus accepted-value scoreboard for the scan controller
module tb_escaneo_display_ctrl;
  localparam int DIV = 10, BL = 2, FR = 4 * DIV;
  logic       clk = 0, reset = 1, enable = 1, estado_valid = 0;
  logic [7:0] estado_in = 0;
  logic       estado_ready, blank, frame_done;
  logic [1:0] conteo;
  logic [7:0] estado;
  escaneo_display_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BL), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .estado_in(estado_in),
    .estado_valid(estado_valid), .estado_ready(estado_ready), .conteo(conteo),
    .estado(estado), .blank(blank), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  bit m_on = 1, m_full = 0, m_fd = 0, m_rst = 0;
  int m_t = 0;
  logic [7:0] m_pend = 0, m_estado = 0, m_last = 0;
  logic [7:0] sb_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // m_t counts cycles since the start of digit 0's SHOW; slot/digit/blank follow by division
  task automatic model_step();
    bit acc, app;
    m_fd = 0;
    m_rst = 0;
    if (reset) begin
      m_on = 1; m_t = 0; m_full = 0; m_estado = 0; m_last = 0; m_rst = 1;
      sb_q.delete();
      return;
    end
    acc = estado_valid && !m_full;
    app = 0;
    if (!m_on || !enable) begin
      app = m_full; m_on = enable; m_t = 0;
    end else begin
      m_t++;
      if (m_t == FR) begin m_t = 0; m_fd = 1; app = m_full; end
    end
    if (app) begin
      m_estado = m_pend; m_full = 0;
    end else if (acc) begin
      m_pend = estado_in; m_full = 1; m_last = estado_in;
      sb_q.push_back(estado_in);
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial begin
    logic [7:0] prev = 0;
    forever begin
      @(negedge clk);
      check("conteo", conteo, m_on ? (m_t / DIV) % 4 : 0);
      check("blank", blank, !m_on || (m_t % DIV) >= DIV - BL);
      check("frame_done", frame_done, m_fd);
      check("estado_ready", estado_ready, !m_full);
      check("estado", estado, m_estado);
      if (!m_rst && estado !== prev) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected at %0t: got %0h expected no change from %0h", $time, estado, prev);
        end else check("sb_order", estado, sb_q.pop_front());
      end
      prev = estado;
    end
  end
  task automatic send(input logic [7:0] d);
    int n = 0;
    estado_in = d;
    estado_valid = 1;
    while (!estado_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout at %0t: got ready=%0b expected ready=1", $time, estado_ready);
    end
    @(negedge clk);
    estado_valid = 0;
  endtask
  task automatic wait_bounded(input int sel, output bit ok);
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      ok = sel == 0 ? estado_ready :
           sel == 1 ? (m_on && m_t == FR - 1) :
           sel == 2 ? (conteo == 2 && !blank) : blank;
      if (!ok) @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_timeout sel=%0d at %0t: got 0 expected 1", sel, $time);
    end
  endtask
  initial begin
    bit ok;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (45) @(negedge clk);
    repeat (5) @(negedge clk);
    send(8'h81);
    send(8'hCF);
    wait_bounded(0, ok);
    wait_bounded(1, ok);
    estado_in = 8'h3C; estado_valid = 1;
    @(negedge clk);
    estado_valid = 0;
    wait_bounded(0, ok);
    send(8'h92);
    wait_bounded(2, ok);
    repeat (2) @(negedge clk);
    enable = 0;
    repeat (3) @(negedge clk);
    enable = 1;
    repeat (15) @(negedge clk);
    send(8'h55);
    wait_bounded(3, ok);
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 70) begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        d = 8'($urandom);
        if (d == m_last) d ^= 8'h01;
        send(d);
      end else if (r < 90) begin
        enable = 0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1;
      end else begin
        reset = 1;
        @(negedge clk);
        reset = 0;
      end
    end
    repeat (100) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
